// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: accepts an ALU effective address, issues a
// request/grant/response memory transaction and returns extended load data.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEG = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        lo_q, lo_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              is_load_c, is_store_c, illegal_c, misaligned_c;
  logic [3:0]        wstrb_c;
  logic [31:0]       wdata_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [31:0]       load_c;

  // Request decode, evaluated against the live inputs while idle
  assign is_load_c  = (opcode == OP_L);
  assign is_store_c = (opcode == OP_S);
  assign illegal_c  = !(is_load_c || is_store_c)
                   || (is_load_c && (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111))
                   || (is_store_c && (func3 > 3'b010));
  assign misaligned_c = ((func3[1:0] == 2'b01) && addr[0])
                     || ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  // Store lane steering
  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdata;
    case (func3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << addr[1:0];
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    byte_c = mem_rdata[7:0];
    case (lo_q)
      2'b00:   byte_c = mem_rdata[7:0];
      2'b01:   byte_c = mem_rdata[15:8];
      2'b10:   byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (illegal_c || misaligned_c) ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = mem_we_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid || (cnt_q == CNT_LIMIT)) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshakes plus next values of the datapath registers
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    resp_valid   = (state_q == S_RESP);
    mem_req      = (state_q == S_REQ);
    cnt_d        = cnt_q;
    func3_d      = func3_q;
    lo_d         = lo_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          func3_d      = func3;
          lo_d         = addr[1:0];
          resp_rdata_d = 32'd0;
          if (illegal_c) begin
            resp_err_d = ERR_ILLEG;
          end else if (misaligned_c) begin
            resp_err_d = ERR_ALIGN;
          end else begin
            resp_err_d  = ERR_OK;
            mem_we_d    = is_store_c;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = is_store_c ? wstrb_c : 4'b0000;
            mem_wdata_d = is_store_c ? wdata_c : 32'd0;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d       = '0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'd0;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          resp_rdata_d = load_c;
          resp_err_d   = ERR_OK;
        end else if (cnt_q == CNT_LIMIT) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = ERR_TMO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        resp_rdata_d = 32'd0;
        resp_err_d   = ERR_OK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      func3_q      <= 3'b000;
      lo_q         <= 2'b00;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'd0;
    end else begin
      cnt_q        <= cnt_d;
      func3_q      <= func3_d;
      lo_q         <= lo_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: stores, loads, errors, timeout and reset.
module tb_lsu_mem_port;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  lsu_mem_port #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .func3      (func3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in cycle N+1
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    opcode    = op;
    func3     = f3;
    addr      = a;
    wdata     = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Load with gnt at N+1 (plus an rvalid that must be ignored) and rvalid at N+2
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(OP_L, f3, a, 32'h0);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, ".we"}, 32'(mem_we), 32'd0);
    chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'd0);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    step();
    mem_gnt = 1'b0;
    chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
    chk({tag, ".no_early"}, 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(resp_err), 32'd0);
    chk({tag, ".rdata"}, resp_rdata, exp);
    step();
    chk({tag, ".one_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, ".rdata_clr"}, resp_rdata, 32'd0);
  endtask

  // Error request: response at N+1, never a memory request
  task automatic do_err(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] exp_err);
    issue(op, f3, a, 32'hFFFF_FFFF);
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ".rdata"}, resp_rdata, 32'd0);
    chk({tag, ".noreq"}, 32'(mem_req), 32'd0);
    step();
    chk({tag, ".noreq2"}, 32'(mem_req), 32'd0);
    chk({tag, ".err_clr"}, 32'(resp_err), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; opcode = 7'h0; func3 = 3'h0; addr = 32'h0;
    wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    step();
    chk("rst.ready", 32'(req_ready), 32'd1);

    // SB with grant after two wait cycles
    issue(OP_S, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    chk("sb.req1", 32'(mem_req), 32'd1);
    chk("sb.ready_lo", 32'(req_ready), 32'd0);
    chk("sb.we", 32'(mem_we), 32'd1);
    chk("sb.addr", mem_addr, 32'h0000_1000);
    chk("sb.wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb.wdata", mem_wdata, 32'hDDDD_DDDD);
    step();
    chk("sb.req2", 32'(mem_req), 32'd1);
    chk("sb.hold_wstrb", 32'(mem_wstrb), 32'h8);
    step();
    chk("sb.req3", 32'(mem_req), 32'd1);
    chk("sb.hold_addr", mem_addr, 32'h0000_1000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sb.req_drop", 32'(mem_req), 32'd0);
    chk("sb.valid", 32'(resp_valid), 32'd1);
    chk("sb.err", 32'(resp_err), 32'd0);
    chk("sb.rdata", resp_rdata, 32'd0);
    step();
    chk("sb.one_pulse", 32'(resp_valid), 32'd0);
    chk("sb.ready", 32'(req_ready), 32'd1);

    // SH upper half, single-cycle grant
    issue(OP_S, 3'b001, 32'h0000_4002, 32'h1234_BEEF);
    chk("sh.wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh.wdata", mem_wdata, 32'hBEEF_BEEF);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sh.valid", 32'(resp_valid), 32'd1);
    step();

    do_load("lb",  3'b000, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001);
    do_load("lb3", 3'b000, 32'h0000_2003, 32'h7F00_0000, 32'h0000_007F);
    do_load("lw",  3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    do_err("lw_mis",  OP_L, 3'b010, 32'h0000_2003, 2'b01);
    do_err("sh_mis",  OP_S, 3'b001, 32'h0000_0001, 2'b01);
    do_err("ld_f011", OP_L, 3'b011, 32'h0000_0000, 2'b10);
    do_err("st_f100", OP_S, 3'b100, 32'h0000_0001, 2'b10);
    do_err("bad_op",  7'b0110011, 3'b000, 32'h0000_0000, 2'b10);

    // Timeout: WAIT entered at index 0, response 64 cycles later
    issue(OP_L, 3'b010, 32'h0000_3000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int k = 0; k < 63; k++) step();
    chk("tmo.not_yet", 32'(resp_valid), 32'd0);
    step();
    chk("tmo.valid", 32'(resp_valid), 32'd1);
    chk("tmo.err", 32'(resp_err), 32'd3);
    chk("tmo.rdata", resp_rdata, 32'd0);
    step();
    chk("tmo.clear", 32'(resp_err), 32'd0);

    // rvalid on the last permitted cycle beats the timeout
    issue(OP_L, 3'b010, 32'h0000_3000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int k = 0; k < 63; k++) step();
    chk("late.not_yet", 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("late.valid", 32'(resp_valid), 32'd1);
    chk("late.err", 32'(resp_err), 32'd0);
    chk("late.rdata", resp_rdata, 32'hCAFE_F00D);
    step();

    // Reset while in WAIT, then a stale rvalid
    issue(OP_L, 3'b010, 32'h0000_5000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw.ready", 32'(req_ready), 32'd1);
    chk("rstw.novalid", 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    chk("rstw.stale", 32'(resp_valid), 32'd0);
    chk("rstw.rdata", resp_rdata, 32'd0);
    step();
    chk("rstw.stale2", 32'(resp_valid), 32'd0);

    // Reset while in REQ drops mem_req next cycle
    issue(OP_S, 3'b010, 32'h0000_6000, 32'h0BAD_F00D);
    chk("rstr.req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstr.req_drop", 32'(mem_req), 32'd0);
    chk("rstr.wstrb", 32'(mem_wstrb), 32'd0);
    chk("rstr.novalid", 32'(resp_valid), 32'd0);
    step();
    chk("rstr.novalid2", 32'(resp_valid), 32'd0);

    // Normal SW after reset
    issue(OP_S, 3'b010, 32'h0000_4000, 32'h1234_5678);
    chk("sw.req", 32'(mem_req), 32'd1);
    chk("sw.we", 32'(mem_we), 32'd1);
    chk("sw.wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw.wdata", mem_wdata, 32'h1234_5678);
    chk("sw.addr", mem_addr, 32'h0000_4000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sw.valid", 32'(resp_valid), 32'd1);
    chk("sw.err", 32'(resp_err), 32'd0);
    step();
    chk("sw.ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
